// File: rtl/cpu_io_pkg.sv
// Shared constants for the CPU memory-mapped I/O port: register offsets,
// segment type and the active-low hex segment table (bit6=g .. bit0=a).
package cpu_io_pkg;

  typedef logic [6:0] seg_t;

  localparam int unsigned OFF_SW     = 0;
  localparam int unsigned OFF_STATUS = 1;
  localparam int unsigned OFF_CTRL   = 2;
  localparam int unsigned OFF_DIG0   = 3;

  localparam seg_t SEG_BLANK = 7'h7F;

  function automatic seg_t hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_seg = 7'h40;
      4'h1:    hex_seg = 7'h79;
      4'h2:    hex_seg = 7'h24;
      4'h3:    hex_seg = 7'h30;
      4'h4:    hex_seg = 7'h19;
      4'h5:    hex_seg = 7'h12;
      4'h6:    hex_seg = 7'h02;
      4'h7:    hex_seg = 7'h78;
      4'h8:    hex_seg = 7'h00;
      4'h9:    hex_seg = 7'h10;
      4'hA:    hex_seg = 7'h08;
      4'hB:    hex_seg = 7'h03;
      4'hC:    hex_seg = 7'h46;
      4'hD:    hex_seg = 7'h21;
      4'hE:    hex_seg = 7'h06;
      4'hF:    hex_seg = 7'h0E;
      default: hex_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_to_7seg
  import cpu_io_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    seg = hex_seg(nibble);
  end

endmodule

// File: rtl/cpu_io_port.sv
// Memory-mapped switch/display port: synchronised switches with change flag,
// control register and N_DISP digit registers driving registered 7-segment outputs.
module cpu_io_port
  import cpu_io_pkg::*;
#(
  parameter int unsigned          WORD_W      = 8,
  parameter int unsigned          ADDR_W      = 5,
  parameter int unsigned          N_DISP      = 4,
  parameter logic [ADDR_W-1:0]    IO_BASE     = 5'h18,
  parameter int unsigned          SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    n_reset,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [WORD_W-1:0]       wdata,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [WORD_W-1:0]       rdata,
  output logic                    rd_valid,
  input  logic [WORD_W-1:0]       sw,
  output logic                    sw_chg,
  output seg_t [N_DISP-1:0]       disp
);

  localparam int unsigned WIN  = N_DISP + 3;
  localparam int unsigned LAST = SYNC_STAGES - 1;

  logic [ADDR_W-1:0]                   off_s;
  logic                                in_win_s, wr_hit_s, rd_hit_s, chg_set_s;
  logic [SYNC_STAGES-1:0][WORD_W-1:0]  sync_q, sync_d;
  logic [WORD_W-1:0]                   prev_q, prev_d;
  logic                                chg_q, chg_d;
  logic                                ctrl_q, ctrl_d;
  logic [N_DISP-1:0][6:0]              dig_raw_q, dig_raw_d;
  logic [N_DISP-1:0]                   dig_blank_q, dig_blank_d;
  seg_t                                hex_s [N_DISP];
  seg_t [N_DISP-1:0]                   disp_q, disp_d;
  logic [WORD_W-1:0]                   dig_word_s [N_DISP];
  logic [WORD_W-1:0]                   rd_mux_s, rdata_q, rdata_d;
  logic                                rd_valid_q, rd_valid_d;

  // Address window decode; a simultaneous write suppresses the read
  always_comb begin
    off_s    = addr - IO_BASE;
    in_win_s = (addr >= IO_BASE) && (off_s < ADDR_W'(WIN));
    wr_hit_s = wr_en && in_win_s;
    rd_hit_s = rd_en && !wr_en && in_win_s;
  end

  // Switch synchroniser and change flag; a new change beats a clearing STATUS read
  always_comb begin
    sync_d[0] = sw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d    = sync_q[LAST];
    chg_set_s = (sync_q[LAST] != prev_q);
    if (chg_set_s) begin
      chg_d = 1'b1;
    end else if (rd_hit_s && (off_s == ADDR_W'(OFF_STATUS))) begin
      chg_d = 1'b0;
    end else begin
      chg_d = chg_q;
    end
  end

  // Register writes; only bit 0 of CTRL and bits [6:0] plus the top bit of DIGk are kept
  always_comb begin
    ctrl_d = (wr_hit_s && (off_s == ADDR_W'(OFF_CTRL))) ? wdata[0] : ctrl_q;
    for (int k = 0; k < N_DISP; k++) begin
      dig_raw_d[k]   = (wr_hit_s && (off_s == ADDR_W'(OFF_DIG0 + k))) ? wdata[6:0] : dig_raw_q[k];
      dig_blank_d[k] = (wr_hit_s && (off_s == ADDR_W'(OFF_DIG0 + k))) ? wdata[WORD_W-1]
                                                                       : dig_blank_q[k];
    end
  end

  for (genvar k = 0; k < N_DISP; k++) begin : g_dig
    hex_to_7seg u_hex (
      .nibble (dig_raw_d[k][3:0]),
      .seg    (hex_s[k])
    );
  end

  // Display is built from next-state registers so it lands on the write edge
  always_comb begin
    for (int k = 0; k < N_DISP; k++) begin
      if (ctrl_d) begin
        disp_d[k] = dig_blank_d[k] ? SEG_BLANK : hex_s[k];
      end else begin
        disp_d[k] = dig_raw_d[k];
      end
    end
  end

  // Read mux; rdata holds its last value between reads
  always_comb begin
    if (off_s == ADDR_W'(OFF_SW)) begin
      rd_mux_s = sync_q[LAST];
    end else if (off_s == ADDR_W'(OFF_STATUS)) begin
      rd_mux_s = {{(WORD_W-1){1'b0}}, chg_q};
    end else if (off_s == ADDR_W'(OFF_CTRL)) begin
      rd_mux_s = {{(WORD_W-1){1'b0}}, ctrl_q};
    end else begin
      rd_mux_s = '0;
    end
    for (int k = 0; k < N_DISP; k++) begin
      dig_word_s[k]           = '0;
      dig_word_s[k][6:0]      = dig_raw_q[k];
      dig_word_s[k][WORD_W-1] = dig_blank_q[k];
      rd_mux_s = (off_s == ADDR_W'(OFF_DIG0 + k)) ? dig_word_s[k] : rd_mux_s;
    end
    rdata_d    = rd_hit_s ? rd_mux_s : rdata_q;
    rd_valid_d = rd_hit_s;
  end

  // State registers
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      sync_q      <= '0;
      prev_q      <= '0;
      chg_q       <= 1'b0;
      ctrl_q      <= 1'b1;
      dig_raw_q   <= '0;
      dig_blank_q <= '1;
      disp_q      <= {N_DISP{SEG_BLANK}};
      rdata_q     <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      chg_q       <= chg_d;
      ctrl_q      <= ctrl_d;
      dig_raw_q   <= dig_raw_d;
      dig_blank_q <= dig_blank_d;
      disp_q      <= disp_d;
      rdata_q     <= rdata_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;
  assign sw_chg   = chg_q;
  assign disp     = disp_q;

endmodule

// File: tb/tb_cpu_io_port.sv
// Directed self-checking bench for cpu_io_port with default parameters.
module tb_cpu_io_port;

  logic             clock = 1'b0;
  logic             n_reset;
  logic [4:0]       addr;
  logic [7:0]       wdata;
  logic             wr_en, rd_en;
  logic [7:0]       rdata;
  logic             rd_valid;
  logic [7:0]       sw;
  logic             sw_chg;
  logic [3:0][6:0]  disp;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cpu_io_port dut (
    .clock    (clock),
    .n_reset  (n_reset),
    .addr     (addr),
    .wdata    (wdata),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .sw       (sw),
    .sw_chg   (sw_chg),
    .disp     (disp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clock);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [7:0] exp, input string tag);
    @(negedge clock);
    addr  = a;
    rd_en = 1'b1;
    @(posedge clock);
    #1;
    rd_en = 1'b0;
    chk({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, rdata}, {24'd0, exp});
  endtask

  initial begin
    n_reset = 1'b0;
    addr    = 5'd0;
    wdata   = 8'd0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    sw      = 8'd0;

    // 1: reset state
    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) chk("reset_disp", {25'd0, disp[k]}, 32'h7F);
    chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_sw_chg", {31'd0, sw_chg}, 32'd0);
    chk("reset_rdata", {24'd0, rdata}, 32'd0);
    @(negedge clock);
    n_reset = 1'b1;

    // 2: hex mode digits
    do_write(5'h1A, 8'h01);
    do_write(5'h1B, 8'h05);
    chk("hex_dig0", {25'd0, disp[0]}, 32'h12);
    chk("hex_dig1_blank", {25'd0, disp[1]}, 32'h7F);
    do_write(5'h1C, 8'h0A);
    chk("hex_dig1", {25'd0, disp[1]}, 32'h08);
    chk("hex_dig0_hold", {25'd0, disp[0]}, 32'h12);
    do_read(5'h1A, 8'h01, "rd_ctrl");
    do_read(5'h1B, 8'h05, "rd_dig0");
    @(posedge clock);
    #1;
    chk("rd_valid_pulse", {31'd0, rd_valid}, 32'd0);
    chk("rdata_hold", {24'd0, rdata}, 32'h05);

    // 3: switch sync and change flag
    @(negedge clock);
    sw = 8'd2;
    repeat (5) @(posedge clock);
    do_read(5'h19, 8'h01, "status_set2");
    do_read(5'h19, 8'h00, "status_clr2");
    do_read(5'h18, 8'h02, "sw_2");
    @(negedge clock);
    sw = 8'd3;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("chg_not_yet", {31'd0, sw_chg}, 32'd0);
    do_read(5'h18, 8'h03, "sw_3");
    chk("chg_set3", {31'd0, sw_chg}, 32'd1);
    do_read(5'h19, 8'h01, "status_set3");
    do_read(5'h19, 8'h00, "status_clr3");
    chk("chg_cleared", {31'd0, sw_chg}, 32'd0);

    // 4: change coinciding with STATUS read
    @(negedge clock);
    sw = 8'd7;
    @(posedge clock);
    @(posedge clock);
    do_read(5'h19, 8'h00, "status_race");
    chk("chg_race_wins", {31'd0, sw_chg}, 32'd1);
    do_read(5'h19, 8'h01, "status_after_race");

    // 5: raw mode, window edges, write+read, unused bits
    do_write(5'h1A, 8'hFE);
    do_write(5'h1D, 8'h40);
    chk("raw_dig2", {25'd0, disp[2]}, 32'h40);
    do_read(5'h1A, 8'h00, "rd_ctrl_raw");
    @(negedge clock);
    addr  = 5'h17;
    rd_en = 1'b1;
    @(posedge clock);
    #1;
    rd_en = 1'b0;
    chk("below_win_valid", {31'd0, rd_valid}, 32'd0);
    chk("below_win_hold", {24'd0, rdata}, 32'd0);
    @(negedge clock);
    addr  = 5'h1F;
    rd_en = 1'b1;
    @(posedge clock);
    #1;
    rd_en = 1'b0;
    chk("above_win_valid", {31'd0, rd_valid}, 32'd0);
    @(negedge clock);
    addr  = 5'h1E;
    wdata = 8'h33;
    wr_en = 1'b1;
    rd_en = 1'b1;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("wr_rd_no_valid", {31'd0, rd_valid}, 32'd0);
    chk("raw_dig3", {25'd0, disp[3]}, 32'h33);
    do_read(5'h1E, 8'h33, "rd_dig3");
    do_read(5'h1D, 8'h40, "rd_dig2");

    // 6: reset during a pending read
    @(negedge clock);
    addr  = 5'h1A;
    rd_en = 1'b1;
    #2;
    n_reset = 1'b0;
    @(posedge clock);
    #1;
    rd_en = 1'b0;
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_sw_chg", {31'd0, sw_chg}, 32'd0);
    for (int k = 0; k < 4; k++) chk("rst_disp", {25'd0, disp[k]}, 32'h7F);
    @(negedge clock);
    n_reset = 1'b1;
    do_read(5'h1A, 8'h01, "rd_ctrl_after_rst");
    do_read(5'h1C, 8'h80, "rd_dig1_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
